// File: rtl/pcie_ss_axis_demux_pkg.sv
// Shared types and helpers for the PCIe SS AXI-S packet demultiplexer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pcie_ss_axis_demux_pkg;

    // Default stream geometry of the PCIe SS AXI-S interface.
    localparam int PCIE_SS_TDATA_WIDTH = 512;
    localparam int PCIE_SS_TUSER_WIDTH = 10;

    // Packet-level demux state.
    typedef enum logic [1:0] {
        SOP  = 2'd0,
        FWD  = 2'd1,
        DROP = 2'd2
    } state_e;

    // Width of the destination field; never narrower than one bit so that
    // a single-channel build still has a "1 = out of range" encoding.
    function automatic int sel_width(input int num_ch);
        return (num_ch > 2) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/pcie_ss_axis_demux_oreg.sv
// One-deep registered AXI-S output stage for a single demux channel.
// Latency: 1 cycle from load to tvalid.
// Backpressure: rdy = ~tvalid | tready, so a held beat can be replaced in the same cycle it drains.
//
// Ports: clk/rst_n; load + in_* (beat from the demux); rdy (stage can take a
// beat this cycle); tvalid/tready/tdata/tkeep/tlast/tuser_vendor (downstream).
module pcie_ss_axis_demux_oreg #(
    parameter int TDATA_WIDTH = 512,
    parameter int TUSER_WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load,
    input  logic [TDATA_WIDTH-1:0]   in_tdata,
    input  logic [TDATA_WIDTH/8-1:0] in_tkeep,
    input  logic                     in_tlast,
    input  logic [TUSER_WIDTH-1:0]   in_tuser_vendor,
    output logic                     rdy,
    output logic                     tvalid,
    input  logic                     tready,
    output logic [TDATA_WIDTH-1:0]   tdata,
    output logic [TDATA_WIDTH/8-1:0] tkeep,
    output logic                     tlast,
    output logic [TUSER_WIDTH-1:0]   tuser_vendor
);

    assign rdy = ~tvalid | tready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tvalid <= 1'b0;
        end else if (load) begin
            tvalid <= 1'b1;
        end else if (tready) begin
            tvalid <= 1'b0;
        end
    end

    // Payload is not reset; it is only meaningful while tvalid is high.
    always_ff @(posedge clk) begin
        if (load) begin
            tdata        <= in_tdata;
            tkeep        <= in_tkeep;
            tlast        <= in_tlast;
            tuser_vendor <= in_tuser_vendor;
        end
    end

endmodule

// File: rtl/pcie_ss_axis_demux.sv
// Packet-aware 1-to-NUM_CH AXI-S demux: destination decoded from the SOP beat, held until tlast.
// Latency: 1 cycle sink accept to source valid; 1 beat/cycle per channel.
// Backpressure: sink_tready follows the target channel's output stage (HOL blocking); dropped packets are always accepted.
//
// Ports: clk, rst_n (sync, active low); sink_* input stream; source_* output
// streams flattened per channel (channel c in slice c); drop_pulse marks an
// accepted out-of-range SOP beat; drop_count saturates at all-ones.
module pcie_ss_axis_demux
    import pcie_ss_axis_demux_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int TDATA_WIDTH = PCIE_SS_TDATA_WIDTH,
    parameter int TUSER_WIDTH = PCIE_SS_TUSER_WIDTH,
    parameter int SEL_LSB     = 0,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            sink_tvalid,
    output logic                            sink_tready,
    input  logic [TDATA_WIDTH-1:0]          sink_tdata,
    input  logic [TDATA_WIDTH/8-1:0]        sink_tkeep,
    input  logic                            sink_tlast,
    input  logic [TUSER_WIDTH-1:0]          sink_tuser_vendor,
    output logic [NUM_CH-1:0]               source_tvalid,
    input  logic [NUM_CH-1:0]               source_tready,
    output logic [NUM_CH*TDATA_WIDTH-1:0]   source_tdata,
    output logic [NUM_CH*TDATA_WIDTH/8-1:0] source_tkeep,
    output logic [NUM_CH-1:0]               source_tlast,
    output logic [NUM_CH*TUSER_WIDTH-1:0]   source_tuser_vendor,
    output logic                            drop_pulse,
    output logic [CNT_WIDTH-1:0]            drop_count
);

    localparam int SEL_W = sel_width(NUM_CH);
    localparam int KW    = TDATA_WIDTH / 8;

    state_e            state;
    logic [SEL_W-1:0]  cur;
    logic [SEL_W-1:0]  sel;
    logic              sel_ok;
    logic [NUM_CH-1:0] oreg_ready;
    logic [(1<<SEL_W)-1:0] rdy_pad;
    logic              route_vld;
    logic [SEL_W-1:0]  route_ch;
    logic              accept;
    logic [NUM_CH-1:0] load;

    assign sel    = sink_tdata[SEL_LSB +: SEL_W];
    assign sel_ok = (32'(sel) < NUM_CH);
    assign accept = sink_tvalid & sink_tready;

    // Zero-padded so any sel encoding indexes a real bit; out-of-range
    // values never reach it because they are gated by sel_ok.
    always_comb begin
        rdy_pad               = '0;
        rdy_pad[NUM_CH-1:0]   = oreg_ready;
    end

    // Target selection and tready; deliberately independent of sink_tvalid.
    always_comb begin
        sink_tready = 1'b1;
        route_vld   = 1'b0;
        route_ch    = sel;
        case (state)
            SOP: begin
                if (sel_ok) begin
                    route_vld   = 1'b1;
                    sink_tready = rdy_pad[sel];
                end
            end
            FWD: begin
                route_vld   = 1'b1;
                route_ch    = cur;
                sink_tready = rdy_pad[cur];
            end
            default: begin
                sink_tready = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= SOP;
            drop_pulse <= 1'b0;
            drop_count <= '0;
        end else begin
            drop_pulse <= 1'b0;
            if (drop_pulse && (drop_count != {CNT_WIDTH{1'b1}})) begin
                drop_count <= drop_count + CNT_WIDTH'(1);
            end
            case (state)
                SOP: begin
                    if (accept) begin
                        if (sel_ok) begin
                            cur <= sel;
                            if (!sink_tlast) state <= FWD;
                        end else begin
                            drop_pulse <= 1'b1;
                            if (!sink_tlast) state <= DROP;
                        end
                    end
                end
                FWD, DROP: begin
                    if (accept && sink_tlast) state <= SOP;
                end
                default: state <= SOP;
            endcase
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign load[c] = accept & route_vld & (route_ch == SEL_W'(c));

        pcie_ss_axis_demux_oreg #(
            .TDATA_WIDTH (TDATA_WIDTH),
            .TUSER_WIDTH (TUSER_WIDTH)
        ) u_oreg (
            .clk             (clk),
            .rst_n           (rst_n),
            .load            (load[c]),
            .in_tdata        (sink_tdata),
            .in_tkeep        (sink_tkeep),
            .in_tlast        (sink_tlast),
            .in_tuser_vendor (sink_tuser_vendor),
            .rdy             (oreg_ready[c]),
            .tvalid          (source_tvalid[c]),
            .tready          (source_tready[c]),
            .tdata           (source_tdata[c*TDATA_WIDTH +: TDATA_WIDTH]),
            .tkeep           (source_tkeep[c*KW +: KW]),
            .tlast           (source_tlast[c]),
            .tuser_vendor    (source_tuser_vendor[c*TUSER_WIDTH +: TUSER_WIDTH])
        );
    end

endmodule

// File: tb/tb_pcie_ss_axis_demux.sv
// Scoreboard bench for pcie_ss_axis_demux (3 channels, 2-bit sel at bit 4, 4-bit drop counter).
// Stimulus issues packets and pushes expected beats per channel; a monitor pops on every output handshake.
module tb_pcie_ss_axis_demux;

    localparam int NUM_CH  = 3;
    localparam int DW      = 64;
    localparam int KW      = DW / 8;
    localparam int UW      = 8;
    localparam int SEL_LSB = 4;
    localparam int SW      = 2;
    localparam int CW      = 4;
    localparam int CNT_MAX = 15;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
        logic [UW-1:0] u;
    } beat_t;

    logic                   clk;
    logic                   rst_n;
    logic                   sink_tvalid;
    logic                   sink_tready;
    logic [DW-1:0]          sink_tdata;
    logic [KW-1:0]          sink_tkeep;
    logic                   sink_tlast;
    logic [UW-1:0]          sink_tuser_vendor;
    logic [NUM_CH-1:0]      source_tvalid;
    logic [NUM_CH-1:0]      source_tready;
    logic [NUM_CH*DW-1:0]   source_tdata;
    logic [NUM_CH*KW-1:0]   source_tkeep;
    logic [NUM_CH-1:0]      source_tlast;
    logic [NUM_CH*UW-1:0]   source_tuser_vendor;
    logic                   drop_pulse;
    logic [CW-1:0]          drop_count;

    pcie_ss_axis_demux #(
        .NUM_CH      (NUM_CH),
        .TDATA_WIDTH (DW),
        .TUSER_WIDTH (UW),
        .SEL_LSB     (SEL_LSB),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .sink_tvalid         (sink_tvalid),
        .sink_tready         (sink_tready),
        .sink_tdata          (sink_tdata),
        .sink_tkeep          (sink_tkeep),
        .sink_tlast          (sink_tlast),
        .sink_tuser_vendor   (sink_tuser_vendor),
        .source_tvalid       (source_tvalid),
        .source_tready       (source_tready),
        .source_tdata        (source_tdata),
        .source_tkeep        (source_tkeep),
        .source_tlast        (source_tlast),
        .source_tuser_vendor (source_tuser_vendor),
        .drop_pulse          (drop_pulse),
        .drop_count          (drop_count)
    );

    // Reference model state: expected beats per channel, expected drops.
    beat_t exp_q [NUM_CH][$];
    int    exp_drops;
    int    pulse_seen;
    int    out_ch_cnt [NUM_CH];
    int    out_cyc [$];
    int    acc_log [$];
    int    checks;
    int    errors;
    int    cyc;
    bit    rdy_rand;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Random downstream backpressure when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_rand) begin
                for (int c = 0; c < NUM_CH; c++)
                    source_tready[c] = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Monitor: every output handshake must match the head of its channel queue.
    always @(negedge clk) begin
        beat_t got;
        beat_t exp;
        if (drop_pulse) pulse_seen++;
        for (int c = 0; c < NUM_CH; c++) begin
            if (source_tvalid[c] && source_tready[c]) begin
                got.d = source_tdata[c*DW +: DW];
                got.k = source_tkeep[c*KW +: KW];
                got.l = source_tlast[c];
                got.u = source_tuser_vendor[c*UW +: UW];
                out_ch_cnt[c]++;
                out_cyc.push_back(cyc);
                checks++;
                if (exp_q[c].size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat ch%0d: got %h, required no beat", c, got);
                end else begin
                    exp = exp_q[c].pop_front();
                    if (got !== exp) begin
                        errors++;
                        $display("FAIL beat_ch%0d: got %h, required %h", c, got, exp);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    function automatic int exp_count();
        return (exp_drops > CNT_MAX) ? CNT_MAX : exp_drops;
    endfunction

    function automatic int pending();
        int n = 0;
        for (int c = 0; c < NUM_CH; c++) n += exp_q[c].size();
        return n;
    endfunction

    // Present one beat and hold it until the DUT accepts it.
    task automatic drive_beat(input beat_t b);
        int  w;
        bit  acc;
        sink_tvalid = 1'b1;
        {sink_tdata, sink_tkeep, sink_tlast, sink_tuser_vendor} = b;
        w   = 0;
        acc = 0;
        while (!acc && w < 300) begin
            @(negedge clk);
            if (sink_tready) acc = 1;
            else w++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no sink_tready in %0d cycles, required acceptance", w);
        end
        acc_log.push_back(cyc);
        @(posedge clk);
        #1;
        sink_tvalid = 1'b0;
    endtask

    // Build a packet, record its expected fate, then drive it.
    task automatic send_pkt(input int sel, input int len, input int gap_max);
        beat_t pkt [$];
        beat_t b;
        int    dest;
        for (int i = 0; i < len; i++) begin
            b.d = {$urandom, $urandom};
            b.k = KW'($urandom);
            b.l = (i == len - 1);
            b.u = UW'($urandom);
            if (i == 0) b.d[SEL_LSB +: SW] = SW'(sel);
            pkt.push_back(b);
        end
        dest = int'(pkt[0].d[SEL_LSB +: SW]);
        if (dest < NUM_CH) begin
            foreach (pkt[i]) exp_q[dest].push_back(pkt[i]);
        end else begin
            exp_drops++;
        end
        foreach (pkt[i]) begin
            drive_beat(pkt[i]);
            repeat ($urandom_range(0, gap_max)) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic drain(input string name);
        int w = 0;
        while (pending() != 0 && w < 1000) begin
            @(posedge clk);
            w++;
        end
        repeat (3) @(posedge clk);
        #1;
        check({name, "_drained"}, 64'(pending()), 64'd0);
        check({name, "_drop_pulses"}, 64'(pulse_seen), 64'(exp_drops));
        check({name, "_drop_count"}, 64'(drop_count), 64'(exp_count()));
    endtask

    initial begin
        int base;
        checks        = 0;
        errors        = 0;
        exp_drops     = 0;
        pulse_seen    = 0;
        rdy_rand      = 0;
        rst_n         = 1'b0;
        sink_tvalid   = 1'b0;
        sink_tdata    = '0;
        sink_tkeep    = '0;
        sink_tlast    = 1'b0;
        sink_tuser_vendor = '0;
        source_tready = '1;
        for (int c = 0; c < NUM_CH; c++) out_ch_cnt[c] = 0;

        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_tvalid", 64'(source_tvalid), 64'd0);
        check("reset_drop_pulse", 64'(drop_pulse), 64'd0);
        check("reset_drop_count", 64'(drop_count), 64'd0);
        @(posedge clk);
        #1;

        // Three back-to-back 4-beat packets, full downstream throughput.
        out_cyc.delete();
        acc_log.delete();
        send_pkt(2, 4, 0);
        send_pkt(0, 4, 0);
        send_pkt(1, 4, 0);
        drain("b2b");
        check("b2b_out_beats", 64'(out_cyc.size()), 64'd12);
        if (out_cyc.size() == 12 && acc_log.size() == 12) begin
            check("b2b_no_bubbles", 64'(out_cyc[11] - out_cyc[0]), 64'd11);
            check("b2b_latency", 64'(out_cyc[0] - acc_log[0]), 64'd1);
        end

        // Downstream stall on ch1 mid-packet must stall the sink.
        base = out_ch_cnt[1];
        fork
            send_pkt(1, 4, 0);
            begin
                int w = 0;
                while ((out_ch_cnt[1] - base) < 2 && w < 100) begin
                    @(posedge clk);
                    #2;
                    w++;
                end
                check("stall_reached", 64'(w < 100), 64'd1);
                source_tready[1] = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check("stall_sink_tready", 64'(sink_tready), 64'd0);
                    check("stall_ch1_tvalid", 64'(source_tvalid[1]), 64'd1);
                end
                @(posedge clk);
                #1;
                source_tready[1] = 1'b1;
            end
        join
        drain("stall");

        // Out-of-range destination: consumed at full rate, nothing emitted.
        out_cyc.delete();
        acc_log.delete();
        send_pkt(3, 3, 0);
        drain("drop");
        check("drop_no_output", 64'(out_cyc.size()), 64'd0);
        check("drop_count_one", 64'(drop_count), 64'd1);
        if (acc_log.size() == 3)
            check("drop_full_rate", 64'(acc_log[2] - acc_log[0]), 64'd2);

        // Single-beat packets alternating ch0/ch1 every cycle.
        out_cyc.delete();
        for (int i = 0; i < 8; i++) send_pkt(i % 2, 1, 0);
        drain("single");
        check("single_out_beats", 64'(out_cyc.size()), 64'd8);
        if (out_cyc.size() == 8)
            check("single_no_bubbles", 64'(out_cyc[7] - out_cyc[0]), 64'd7);

        // Randomized traffic with random backpressure and gaps.
        rdy_rand = 1;
        for (int i = 0; i < 60; i++)
            send_pkt($urandom_range(0, 3), $urandom_range(1, 5), 2);
        drain("random");
        rdy_rand = 0;
        @(posedge clk);
        #2;
        source_tready = '1;

        // Drop counter saturation.
        for (int i = 0; i < 20; i++) send_pkt(3, $urandom_range(1, 3), 0);
        drain("saturate");
        check("saturate_count_15", 64'(drop_count), 64'd15);

        // Reset in the middle of a packet: beats 1-2 delivered, then reset.
        begin
            beat_t b;
            for (int i = 0; i < 2; i++) begin
                b.d = {$urandom, $urandom};
                b.k = KW'($urandom);
                b.l = 1'b0;
                b.u = UW'($urandom);
                if (i == 0) b.d[SEL_LSB +: SW] = 2'd2;
                exp_q[2].push_back(b);
                drive_beat(b);
            end
        end
        repeat (3) @(posedge clk);
        #1;
        check("midpkt_delivered", 64'(pending()), 64'd0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        exp_drops  = 0;
        pulse_seen = 0;
        @(negedge clk);
        check("midrst_tvalid", 64'(source_tvalid), 64'd0);
        check("midrst_drop_count", 64'(drop_count), 64'd0);
        @(posedge clk);
        #1;
        send_pkt(1, 3, 0);
        drain("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
